sys_cmd_decoder: RTL and testbench

//  Command-frame decoder between UART RX and the register file, ALU and TX FIFO.

---
 rtl/sys_cmd_pkg.sv | 45 ++++
 rtl/cmd_frame_timer.sv | 38 +++
 rtl/sys_cmd_decoder.sv | 184 ++++++++++++++++++
 tb/tb_sys_cmd_decoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cmd_pkg.sv
// Shared constants for the UART command-frame decoder: frame opcodes,
// FSM state encoding, ALU function codes and a state-class helper.
package sys_cmd_pkg;

  // Frame opcodes (first byte of every frame)
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_OP_A     = 4'd5;
  localparam logic [3:0] ST_OP_B     = 4'd6;
  localparam logic [3:0] ST_FUN      = 4'd7;
  localparam logic [3:0] ST_ALU_WAIT = 4'd8;
  localparam logic [3:0] ST_TX_PUSH  = 4'd9;

  // ALU function codes understood by the downstream ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_NAND = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;

  // True for states that are still collecting frame bytes; only these
  // states react to RX errors and the inter-byte timeout.
  function automatic logic is_frame_state(input logic [3:0] st);
    logic r;
    case (st)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
      ST_OP_A, ST_OP_B, ST_FUN: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_frame_timer.sv
// Inter-byte timeout counter for the command decoder.
// Compiled only when CMD_TIMEOUT_EN is defined.
`ifdef CMD_TIMEOUT_EN
module cmd_frame_timer #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // Restart on every accepted byte, advance while a frame is being collected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Fires in the last idle cycle of the window; a byte arriving in that
  // same cycle wins over the timeout.
  always_comb begin
    expired = count_en && !load && (cnt == CW'(CYCLES - 1));
  end

endmodule
`endif

// File: rtl/sys_cmd_decoder.sv
// Command-frame decoder: parses AA/BB/CC/DD frames from the UART receiver,
// drives register-file and ALU strobes, and pushes read/ALU results into
// the TX FIFO. Single clock domain (REF clock).
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte frame timeout).
module sys_cmd_decoder
  import sys_cmd_pkg::*;
#(
  parameter int Data_width     = 8,
  parameter int Address_width  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Data_width-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     RX_ERR,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [Address_width-1:0] RF_ADDR,
  output logic [Data_width-1:0]    RF_WR_DATA,
  input  logic [Data_width-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_DATA_VLD,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_GATE_EN,
  input  logic [Data_width-1:0]    ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic [Data_width-1:0]    TX_WR_DATA,
  output logic                     TX_WR_EN,
  input  logic                     TX_FULL,
  output logic                     BUSY
);

  logic [3:0]               state;
  logic [3:0]               state_nxt;
  logic [Address_width-1:0] wr_addr;
  logic                     byte_ok;
  logic                     byte_err;
  logic                     in_frame;
  logic                     timeout;
  logic [7:0]               opcode;

  assign byte_ok  = RX_D_VLD & ~RX_ERR;
  assign byte_err = RX_D_VLD &  RX_ERR;
  assign in_frame = is_frame_state(state);
  assign opcode   = RX_P_DATA[7:0];

`ifdef CMD_TIMEOUT_EN
  cmd_frame_timer #(
    .CYCLES   (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (byte_ok),
    .count_en (in_frame),
    .expired  (timeout)
  );
`else
  // Constant false: frames wait indefinitely for their next byte.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode; errors and timeouts only abort byte-collecting states
  always_comb begin
    state_nxt = state;
    if (in_frame && (byte_err || timeout)) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (byte_ok) begin
            case (opcode)
              CMD_RF_WR:   state_nxt = ST_WR_ADDR;
              CMD_RF_RD:   state_nxt = ST_RD_ADDR;
              CMD_ALU_OP:  state_nxt = ST_OP_A;
              CMD_ALU_NOP: state_nxt = ST_FUN;
              default:     state_nxt = ST_IDLE;
            endcase
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_WR_ADDR:  state_nxt = byte_ok        ? ST_WR_DATA  : state;
        ST_WR_DATA:  state_nxt = byte_ok        ? ST_IDLE     : state;
        ST_RD_ADDR:  state_nxt = byte_ok        ? ST_RD_WAIT  : state;
        ST_RD_WAIT:  state_nxt = RF_RD_DATA_VLD ? ST_TX_PUSH  : state;
        ST_OP_A:     state_nxt = byte_ok        ? ST_OP_B     : state;
        ST_OP_B:     state_nxt = byte_ok        ? ST_FUN      : state;
        ST_FUN:      state_nxt = byte_ok        ? ST_ALU_WAIT : state;
        ST_ALU_WAIT: state_nxt = ALU_OUT_VLD    ? ST_TX_PUSH  : state;
        ST_TX_PUSH:  state_nxt = !TX_FULL       ? ST_IDLE     : state;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and busy flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != ST_IDLE);
    end
  end

  // Datapath and strobes. byte_ok never coincides with an abort, so keying
  // side effects on byte_ok keeps aborted frames free of RF/ALU activity.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      ALU_FUN     <= 4'd0;
      TX_WR_DATA  <= '0;
      TX_WR_EN    <= 1'b0;
      wr_addr     <= '0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      TX_WR_EN <= 1'b0;
      case (state)
        ST_WR_ADDR: begin
          if (byte_ok) wr_addr <= RX_P_DATA[Address_width-1:0];
        end
        ST_WR_DATA: begin
          if (byte_ok) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= wr_addr;
            RF_WR_DATA <= RX_P_DATA;
          end
        end
        ST_RD_ADDR: begin
          if (byte_ok) begin
            RF_RD_EN <= 1'b1;
            RF_ADDR  <= RX_P_DATA[Address_width-1:0];
          end
        end
        ST_RD_WAIT: begin
          if (RF_RD_DATA_VLD) TX_WR_DATA <= RF_RD_DATA;
        end
        ST_OP_A: begin
          if (byte_ok) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= Address_width'(0);
            RF_WR_DATA <= RX_P_DATA;
          end
        end
        ST_OP_B: begin
          if (byte_ok) begin
            RF_WR_EN   <= 1'b1;
            RF_ADDR    <= Address_width'(1);
            RF_WR_DATA <= RX_P_DATA;
          end
        end
        ST_FUN: begin
          if (byte_ok) begin
            ALU_FUN     <= RX_P_DATA[3:0];
            ALU_EN      <= 1'b1;
            CLK_GATE_EN <= 1'b1;
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            TX_WR_DATA  <= ALU_OUT;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
          end
        end
        ST_TX_PUSH: begin
          if (!TX_FULL) TX_WR_EN <= 1'b1;
        end
        default: begin
          wr_addr <= wr_addr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Self-checking bench for sys_cmd_decoder: directed frames from the
// datasheet examples plus randomized frames, checked against a frame-level
// model of the register file and ALU.
`timescale 1ns/1ps
module tb_sys_cmd_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       RX_ERR;
  logic       RF_WR_EN;
  logic       RF_RD_EN;
  logic [3:0] RF_ADDR;
  logic [7:0] RF_WR_DATA;
  logic [7:0] RF_RD_DATA;
  logic       RF_RD_DATA_VLD;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_GATE_EN;
  logic [7:0] ALU_OUT;
  logic       ALU_OUT_VLD;
  logic [7:0] TX_WR_DATA;
  logic       TX_WR_EN;
  logic       TX_FULL;
  logic       BUSY;

  always #5 CLK = ~CLK;

  sys_cmd_decoder #(
    .Data_width     (8),
    .Address_width  (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_P_DATA      (RX_P_DATA),
    .RX_D_VLD       (RX_D_VLD),
    .RX_ERR         (RX_ERR),
    .RF_WR_EN       (RF_WR_EN),
    .RF_RD_EN       (RF_RD_EN),
    .RF_ADDR        (RF_ADDR),
    .RF_WR_DATA     (RF_WR_DATA),
    .RF_RD_DATA     (RF_RD_DATA),
    .RF_RD_DATA_VLD (RF_RD_DATA_VLD),
    .ALU_EN         (ALU_EN),
    .ALU_FUN        (ALU_FUN),
    .CLK_GATE_EN    (CLK_GATE_EN),
    .ALU_OUT        (ALU_OUT),
    .ALU_OUT_VLD    (ALU_OUT_VLD),
    .TX_WR_DATA     (TX_WR_DATA),
    .TX_WR_EN       (TX_WR_EN),
    .TX_FULL        (TX_FULL),
    .BUSY           (BUSY)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment register file (what the DUT talks to) and the model's view
  logic [7:0] rf_mem [16];
  logic [7:0] exp_rf [16];

  function automatic logic [7:0] alu_ref(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (fun)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      4'd6:    r = ~(a & b);
      4'd7:    r = ~(a | b);
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Observed DUT activity
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [3:0] rd_q      [$];
  logic [7:0] tx_q      [$];
  int overlap_cnt   = 0;
  int full_push_cnt = 0;
  int gate_cnt      = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (RST === 1'b0) begin
        if (RF_WR_EN) begin wr_addr_q.push_back(RF_ADDR); wr_data_q.push_back(RF_WR_DATA); end
        if (RF_RD_EN) rd_q.push_back(RF_ADDR);
        if (TX_WR_EN) tx_q.push_back(TX_WR_DATA);
        if (RF_WR_EN && RF_RD_EN) overlap_cnt++;
        if (TX_WR_EN && TX_FULL) full_push_cnt++;
        if (CLK_GATE_EN !== ALU_EN) gate_cnt++;
      end
    end
  end

  // Register-file responder: writes land, reads answer one cycle later
  initial begin
    RF_RD_DATA = 8'd0;
    RF_RD_DATA_VLD = 1'b0;
    forever begin
      @(posedge CLK); #1;
      RF_RD_DATA_VLD = 1'b0;
      if (RST === 1'b0) begin
        if (RF_WR_EN) rf_mem[RF_ADDR] = RF_WR_DATA;
        if (RF_RD_EN) begin RF_RD_DATA = rf_mem[RF_ADDR]; RF_RD_DATA_VLD = 1'b1; end
      end
    end
  end

  // ALU responder with random latency
  int alu_lat_min = 0;
  int alu_lat_max = 3;
  initial begin
    int alu_cnt;
    alu_cnt = -1;
    ALU_OUT = 8'd0;
    ALU_OUT_VLD = 1'b0;
    forever begin
      @(posedge CLK); #1;
      ALU_OUT_VLD = 1'b0;
      if (RST !== 1'b0 || !ALU_EN) alu_cnt = -1;
      else if (alu_cnt < 0) alu_cnt = int'($urandom_range(alu_lat_max, alu_lat_min));
      else if (alu_cnt == 0) begin
        ALU_OUT = alu_ref(ALU_FUN, rf_mem[0], rf_mem[1]);
        ALU_OUT_VLD = 1'b1;
        alu_cnt = 1000;
      end
      else if (alu_cnt < 1000) alu_cnt--;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic gap();
    tick(int'($urandom_range(2, 0)));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    RX_P_DATA = b; RX_ERR = err; RX_D_VLD = 1'b1;
    tick(1);
    RX_D_VLD = 1'b0; RX_ERR = 1'b0;
  endtask

  task automatic clear_q();
    wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete(); tx_q.delete();
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (tx_q.size() == 0 && n < 200) begin tick(1); n++; end
    tick(3);
    check_eq({tag, "_txcnt"}, 32'(tx_q.size()), 32'd1);
    if (tx_q.size() > 0) check_eq({tag, "_txdata"}, 32'(tx_q[0]), 32'(exp));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    clear_q();
    send_byte(8'hAA, 1'b0);
    check_eq("wr_busy", 32'(BUSY), 32'd1);
    gap(); send_byte(a, 1'b0);
    gap(); send_byte(d, 1'b0);
    check_eq("wr_strobe", 32'(RF_WR_EN), 32'd1);
    tick(2);
    exp_rf[a[3:0]] = d;
    check_eq("wr_cnt", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check_eq("wr_addr", 32'(wr_addr_q[0]), 32'(a[3:0]));
      check_eq("wr_data", 32'(wr_data_q[0]), 32'(d));
    end
    check_eq("wr_side", 32'(rd_q.size() + tx_q.size()), 32'd0);
    check_eq("wr_idle", 32'(BUSY), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input int full_cycles);
    logic [7:0] exp;
    exp = exp_rf[a[3:0]];
    clear_q();
    if (full_cycles > 0) TX_FULL = 1'b1;
    send_byte(8'hBB, 1'b0);
    gap(); send_byte(a, 1'b0);
    check_eq("rd_strobe", 32'(RF_RD_EN), 32'd1);
    if (full_cycles > 0) begin
      tick(full_cycles);
      check_eq("rd_full_nopush", 32'(tx_q.size()), 32'd0);
      check_eq("rd_full_held", 32'(TX_WR_DATA), 32'(exp));
      TX_FULL = 1'b0;
    end
    expect_tx("rd", exp);
    check_eq("rd_cnt", 32'(rd_q.size()), 32'd1);
    if (rd_q.size() > 0) check_eq("rd_addr", 32'(rd_q[0]), 32'(a[3:0]));
    check_eq("rd_nowr", 32'(wr_addr_q.size()), 32'd0);
    check_eq("rd_idle", 32'(BUSY), 32'd0);
  endtask

  task automatic alu_frame(input bit load_ops, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] f, input int full_cycles);
    logic [7:0] exp;
    clear_q();
    if (load_ops) begin exp_rf[0] = a; exp_rf[1] = b; end
    exp = alu_ref(f[3:0], exp_rf[0], exp_rf[1]);
    if (full_cycles > 0) TX_FULL = 1'b1;
    if (load_ops) begin
      send_byte(8'hCC, 1'b0); gap();
      send_byte(a, 1'b0); gap();
      send_byte(b, 1'b0); gap();
    end else begin
      send_byte(8'hDD, 1'b0); gap();
    end
    send_byte(f, 1'b0);
    check_eq("alu_en", 32'(ALU_EN), 32'd1);
    check_eq("alu_fun", 32'(ALU_FUN), 32'(f[3:0]));
    if (full_cycles > 0) begin
      tick(full_cycles);
      check_eq("alu_full_nopush", 32'(tx_q.size()), 32'd0);
      check_eq("alu_full_held", 32'(TX_WR_DATA), 32'(exp));
      TX_FULL = 1'b0;
    end
    expect_tx("alu", exp);
    check_eq("alu_wrcnt", 32'(wr_addr_q.size()), load_ops ? 32'd2 : 32'd0);
    if (load_ops && wr_addr_q.size() == 2) begin
      check_eq("alu_opa", {24'd0, wr_addr_q[0], wr_data_q[0][3:0]}, {24'd0, 4'd0, a[3:0]});
      check_eq("alu_opa_data", 32'(wr_data_q[0]), 32'(a));
      check_eq("alu_opb", 32'(wr_addr_q[1]), 32'd1);
      check_eq("alu_opb_data", 32'(wr_data_q[1]), 32'(b));
    end
    check_eq("alu_nord", 32'(rd_q.size()), 32'd0);
    check_eq("alu_en_off", 32'(ALU_EN), 32'd0);
    check_eq("alu_idle", 32'(BUSY), 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return {2'd0, RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
            CLK_GATE_EN, TX_WR_DATA, TX_WR_EN, BUSY};
  endfunction

  initial begin
    logic [7:0] junk;
    RST = 1'b1; RX_P_DATA = 8'd0; RX_D_VLD = 1'b0; RX_ERR = 1'b0; TX_FULL = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'($urandom);
      exp_rf[i] = rf_mem[i];
    end
    tick(3);
    check_eq("reset_outputs", all_outputs(), 32'd0);
    RST = 1'b0;
    tick(2);

    // Datasheet examples
    do_write(8'h05, 8'h55);
    do_read(8'h05, 0);
    alu_frame(1'b1, 8'h0A, 8'h19, 8'h00, 0);
    check_eq("add_example", 32'(alu_ref(4'd0, exp_rf[0], exp_rf[1])), 32'h23);
    do_write(8'h00, 8'h14);
    do_write(8'h01, 8'h04);
    alu_frame(1'b0, 8'h00, 8'h00, 8'h06, 10);

    // RX error mid-frame aborts, trailing byte is junk
    clear_q();
    send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h55, 1'b1);
    tick(2);
    check_eq("err_idle", 32'(BUSY), 32'd0);
    send_byte(8'h55, 1'b0);
    tick(2);
    check_eq("err_nowrite", 32'(wr_addr_q.size() + rd_q.size() + tx_q.size()), 32'd0);

    // Bytes during ALU_WAIT are dropped
    alu_lat_min = 6; alu_lat_max = 6;
    clear_q();
    send_byte(8'hDD, 1'b0); send_byte(8'h00, 1'b0);
    tick(1);
    check_eq("drop_alu_en", 32'(ALU_EN), 32'd1);
    send_byte(8'hBB, 1'b0); send_byte(8'h05, 1'b0);
    expect_tx("drop", alu_ref(4'd0, exp_rf[0], exp_rf[1]));
    check_eq("drop_nord", 32'(rd_q.size()), 32'd0);
    alu_lat_min = 0; alu_lat_max = 3;
    do_write(8'h07, 8'h3C);

    // Reset mid-frame
    clear_q();
    send_byte(8'hAA, 1'b0); send_byte(8'h05, 1'b0);
    RST = 1'b1;
    tick(1);
    check_eq("rst_mid_outputs", all_outputs(), 32'd0);
    RST = 1'b0;
    tick(1);
    send_byte(8'h55, 1'b0);
    tick(2);
    check_eq("rst_mid_nowrite", 32'(wr_addr_q.size()), 32'd0);
    check_eq("rst_mid_idle", 32'(BUSY), 32'd0);

`ifdef CMD_TIMEOUT_EN
    clear_q();
    send_byte(8'hAA, 1'b0);
    tick(20);
    check_eq("to_idle", 32'(BUSY), 32'd0);
    send_byte(8'h05, 1'b0); send_byte(8'h55, 1'b0);
    tick(2);
    check_eq("to_nowrite", 32'(wr_addr_q.size()), 32'd0);
    check_eq("to_junk_idle", 32'(BUSY), 32'd0);
    clear_q();
    send_byte(8'hAA, 1'b0); tick(12);
    send_byte(8'h03, 1'b0); tick(12);
    send_byte(8'h77, 1'b0);
    check_eq("to_reload_strobe", 32'(RF_WR_EN), 32'd1);
    exp_rf[3] = 8'h77;
    tick(2);
`endif

    // Randomized frames
    for (int i = 0; i < 60; i++) begin
      int kind;
      int full;
      kind = int'($urandom_range(4, 0));
      full = ($urandom_range(3, 0) == 0) ? 10 : 0;
      case (kind)
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), full);
        2: alu_frame(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), full);
        3: alu_frame(1'b0, 8'd0, 8'd0, 8'($urandom), full);
        default: begin
          clear_q();
          junk = 8'($urandom);
          while (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'($urandom);
          send_byte(junk, 1'b0);
          tick(2);
          check_eq("junk_quiet", 32'(wr_addr_q.size() + rd_q.size() + tx_q.size() + int'(BUSY)), 32'd0);
        end
      endcase
    end

    check_eq("wr_rd_overlap", 32'(overlap_cnt), 32'd0);
    check_eq("push_while_full", 32'(full_push_cnt), 32'd0);
    check_eq("clk_gate_tracks_alu_en", 32'(gate_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
